// File: rtl/cheshire_sim_uart_pkg.sv
// -----------------------------------------------------------------------------
// cheshire_sim_uart_pkg
// Shared types for the simulation-side UART receiver: receiver FSM states,
// the FIFO entry layout and the character width.
// -----------------------------------------------------------------------------
package cheshire_sim_uart_pkg;

   localparam int unsigned DataBits = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } uart_state_e;

   typedef struct packed {
      logic                frame_err;
      logic [DataBits-1:0] data;
   } uart_entry_t;

endpackage

// File: rtl/cheshire_sim_uart_fifo.sv
// -----------------------------------------------------------------------------
// cheshire_sim_uart_fifo
// First-word-fall-through FIFO with asynchronous active-high reset.
// Pointers carry one extra wrap bit, so full and empty are told apart without
// a separate occupancy counter.
//
// Ports:
//   clk_i    in   clock
//   rst_i    in   asynchronous, active-high reset (FIFO becomes empty)
//   push_i   in   write data_i; accepted when not full or popping this cycle
//   data_i   in   entry to write
//   full_o   out  all Depth entries occupied
//   pop_i    in   discard the head entry; ignored while empty
//   empty_o  out  no entry stored
//   head_o   out  oldest stored entry (undefined while empty)
// -----------------------------------------------------------------------------
module cheshire_sim_uart_fifo
   import cheshire_sim_uart_pkg::*;
#(
   parameter type         entry_t = uart_entry_t,
   parameter int unsigned Depth   = 16
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   push_i,
   input  entry_t data_i,
   output logic   full_o,
   input  logic   pop_i,
   output logic   empty_o,
   output entry_t head_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [PtrW:0] r_wr_ptr;
   logic [PtrW:0] r_rd_ptr;
   entry_t        r_mem [Depth];
   logic          w_do_push;
   logic          w_do_pop;

   assign empty_o = (r_wr_ptr == r_rd_ptr);
   assign full_o  = (r_wr_ptr[PtrW] != r_rd_ptr[PtrW]) &&
                    (r_wr_ptr[PtrW-1:0] == r_rd_ptr[PtrW-1:0]);

   // A pop frees a slot in the same cycle, so a full FIFO still accepts a
   // push that coincides with a pop.
   assign w_do_pop  = pop_i & ~empty_o;
   assign w_do_push = push_i & (~full_o | w_do_pop);

   assign head_o = r_mem[r_rd_ptr[PtrW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which
   // entries are valid, and a resettable array would cost a flop per bit.
   always_ff @(posedge clk_i) begin
      if (w_do_push) r_mem[r_wr_ptr[PtrW-1:0]] <= data_i;
   end

endmodule

// File: rtl/cheshire_sim_uart_rx.sv
// -----------------------------------------------------------------------------
// cheshire_sim_uart_rx
// Simulation-side UART receiver for the Cheshire uart_tx line. Oversamples
// with the system clock, deframes 8N1 characters (8E1 when
// CHESHIRE_SIM_UART_PARITY_EN is defined) and buffers them in a small FIFO
// that the harness drains through a valid/ready port.
//
// Ports:
//   clk_i        in   system clock
//   rst_i        in   asynchronous, active-high reset
//   rx_i         in   serial line, idles high
//   data_o       out  head-of-FIFO character (0 while empty)
//   frame_err_o  out  head character had a bad stop (or parity) bit
//   valid_o      out  FIFO not empty
//   ready_i      in   consumer accepts the head entry
//   busy_o       out  receiver FSM not idle
//   overflow_o   out  sticky: at least one character dropped
//   drop_cnt_o   out  saturating count of dropped characters
//
// Macro CHESHIRE_SIM_UART_PARITY_EN: adds an even-parity bit after the data.
// -----------------------------------------------------------------------------
module cheshire_sim_uart_rx
   import cheshire_sim_uart_pkg::*;
#(
   parameter int unsigned ClkPerBit    = 1736,
   parameter int unsigned FifoDepth    = 16,
   parameter int unsigned DropCntWidth = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    rx_i,
   output logic [DataBits-1:0]     data_o,
   output logic                    frame_err_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    busy_o,
   output logic                    overflow_o,
   output logic [DropCntWidth-1:0] drop_cnt_o
);

   localparam int unsigned   CntW     = $clog2(ClkPerBit);
   localparam int unsigned   IdxW     = $clog2(DataBits);
   localparam logic [CntW-1:0] HalfLoad = CntW'(ClkPerBit / 2 - 1);
   localparam logic [CntW-1:0] FullLoad = CntW'(ClkPerBit - 1);

   logic [1:0]              r_sync;
   logic                    w_rxs;
   uart_state_e             r_state,   w_state_nxt;
   logic [CntW-1:0]         r_cnt,     w_cnt_nxt;
   logic [IdxW-1:0]         r_bit_idx, w_bit_idx_nxt;
   logic [DataBits-1:0]     r_shift,   w_shift_nxt;
   logic                    r_par_err, w_par_err_nxt;
   logic                    w_sample;
   logic                    w_push;
   uart_entry_t             w_push_entry;
   uart_entry_t             w_head;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_pop;
   logic                    w_drop;
   logic                    r_overflow;
   logic [DropCntWidth-1:0] r_drop_cnt;

   // Two-flop synchronizer; resets to the idle-high line level so no false
   // start bit is seen on reset release.
   // NOTE: clocked blocks use non-blocking assignments so every flop samples
   // the values from before the edge, whatever the block order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], rx_i};
   end
   assign w_rxs = r_sync[1];

   // The bit timer only matters outside IDLE; zero marks a sample point.
   assign w_sample = (r_cnt == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_par_err <= w_par_err_nxt;
      end
   end

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt            = r_state;
      w_cnt_nxt              = r_cnt;
      w_bit_idx_nxt          = r_bit_idx;
      w_shift_nxt            = r_shift;
      w_par_err_nxt          = r_par_err;
      w_push                 = 1'b0;
      w_push_entry.frame_err = ~w_rxs | r_par_err;
      w_push_entry.data      = r_shift;

      if (r_state != IDLE) w_cnt_nxt = w_sample ? FullLoad : r_cnt - 1'b1;

      case (r_state)
         IDLE: begin
            if (!w_rxs) begin
               // Half a bit to the middle of the start bit.
               w_state_nxt   = START;
               w_cnt_nxt     = HalfLoad;
               w_par_err_nxt = 1'b0;
            end
         end
         START: begin
            if (w_sample) begin
               w_bit_idx_nxt = '0;
               w_state_nxt   = w_rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (w_sample) begin
               // LSB arrives first, so shift in from the top.
               w_shift_nxt   = {w_rxs, r_shift[DataBits-1:1]};
               w_bit_idx_nxt = r_bit_idx + 1'b1;
               if (r_bit_idx == IdxW'(DataBits - 1)) begin
`ifdef CHESHIRE_SIM_UART_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end
            end
         end
         PARITY: begin
            if (w_sample) begin
               // Even parity: the parity bit equals the XOR of the data bits.
               w_par_err_nxt = w_rxs ^ (^r_shift);
               w_state_nxt   = STOP;
            end
         end
         STOP: begin
            if (w_sample) begin
               w_push      = 1'b1;
               w_state_nxt = w_rxs ? IDLE : BREAK;
            end
         end
         BREAK: begin
            // Line held low past the stop bit: wait it out without pushing.
            if (w_rxs) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_pop  = ~w_empty & ready_i;
   assign w_drop = w_push & w_full & ~w_pop;

   cheshire_sim_uart_fifo #(
      .entry_t (uart_entry_t),
      .Depth   (FifoDepth)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .data_i  (w_push_entry),
      .full_o  (w_full),
      .pop_i   (w_pop),
      .empty_o (w_empty),
      .head_o  (w_head)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   // Gate the head so the unreset storage never shows on the outputs.
   assign valid_o     = ~w_empty;
   assign data_o      = w_empty ? '0 : w_head.data;
   assign frame_err_o = ~w_empty & w_head.frame_err;
   assign busy_o      = (r_state != IDLE);
   assign overflow_o  = r_overflow;
   assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_cheshire_sim_uart_rx.sv
module tb_cheshire_sim_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int DCW   = 16;
`ifdef CHESHIRE_SIM_UART_PARITY_EN
   localparam bit ParEn = 1'b1;
`else
   localparam bit ParEn = 1'b0;
`endif
   // Cycles from the rx_i falling edge until the entry is first poppable:
   // sync (2) + half bit + data/parity/stop bits + 1 cycle FIFO write.
   localparam int ExpLat = 2 + CPB / 2 + (9 + int'(ParEn)) * CPB + 1;

   logic           clk     = 1'b0;
   logic           rst_i   = 1'b1;
   logic           rx_i    = 1'b1;
   logic           ready_i = 1'b0;
   logic [7:0]     data_o;
   logic           frame_err_o;
   logic           valid_o;
   logic           busy_o;
   logic           overflow_o;
   logic [DCW-1:0] drop_cnt_o;

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc   = 0;
   int unsigned first_pop_cyc = 0;
   logic [8:0]  exp_q[$];
   logic [8:0]  got_q[$];

   cheshire_sim_uart_rx #(
      .ClkPerBit    (CPB),
      .FifoDepth    (DEPTH),
      .DropCntWidth (DCW)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .frame_err_o (frame_err_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .busy_o      (busy_o),
      .overflow_o  (overflow_o),
      .drop_cnt_o  (drop_cnt_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Inputs change #1 after posedge, so at negedge they are stable and a
   // valid && ready seen here is the handshake of the coming edge.
   always @(negedge clk) begin
      if (!rst_i && valid_o && ready_i) begin
         if (got_q.size() == 0) first_pop_cyc = cyc;
         got_q.push_back({frame_err_o, data_o});
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1);
   end

   // Reference model: the entry a frame must produce.
   function automatic logic [8:0] model(input logic [7:0] b, input logic par_bit,
                                        input logic stop_lvl);
      logic err;
      err = !stop_lvl;
      if (ParEn && (par_bit != ^b)) err = 1'b1;
      return {err, b};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i   = 1'b1;
      rx_i    = 1'b1;
      ready_i = 1'b0;
      tick(2);
      rst_i = 1'b0;
      tick(2);
      exp_q.delete();
      got_q.delete();
   endtask

   // Drives start, data, optional parity and the stop level; leaves rx_i at
   // the stop level when done.
   task automatic drive_frame(input logic [7:0] b, input logic par_bit,
                              input logic stop_lvl, input int stop_cycles);
      rx_i = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         tick(CPB);
      end
      if (ParEn) begin
         rx_i = par_bit;
         tick(CPB);
      end
      rx_i = stop_lvl;
      tick(stop_cycles);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic par_bit, input logic stop_lvl);
      drive_frame(b, par_bit, stop_lvl, CPB);
      rx_i = 1'b1;
      tick(CPB);
      exp_q.push_back(model(b, par_bit, stop_lvl));
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      tick(2);
      n_vec++;
      if ({data_o, frame_err_o, valid_o, busy_o, overflow_o, drop_cnt_o} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got data=%h ferr=%b valid=%b busy=%b ovf=%b drops=%0d exp all 0",
                  data_o, frame_err_o, valid_o, busy_o, overflow_o, drop_cnt_o);
      end
      do_reset();
   endtask

   task automatic test_single();
      int unsigned c0;
      int          lat;
      do_reset();
      ready_i = 1'b1;
      c0 = cyc;
      send_byte(8'h55, ^8'h55, 1'b1);
      tick(4);
      lat = int'(first_pop_cyc - c0);
      n_vec++;
      if (got_q.size() != 1) begin
         n_err++;
         $display("FAIL single_count got %0d exp 1", got_q.size());
      end
      n_vec++;
      if (got_q.size() == 0 || got_q[0] !== 9'h055) begin
         n_err++;
         $display("FAIL single_entry got %h exp 055", (got_q.size() > 0) ? got_q[0] : 9'h1ff);
      end
      n_vec++;
      if (lat < ExpLat - 1 || lat > ExpLat + 2) begin
         n_err++;
         $display("FAIL single_latency got %0d exp %0d..%0d", lat, ExpLat - 1, ExpLat + 2);
      end
   endtask

   task automatic test_break();
      logic [8:0] e;
      do_reset();
      ready_i = 1'b1;
      e = model(8'hA3, ^8'hA3, 1'b0);
      drive_frame(8'hA3, ^8'hA3, 1'b0, 3 * CPB);
      n_vec++;
      if (busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL break_busy_low got %b exp 1", busy_o);
      end
      n_vec++;
      if (got_q.size() == 0 || got_q[0] !== e) begin
         n_err++;
         $display("FAIL break_entry got %h exp %h", (got_q.size() > 0) ? got_q[0] : 9'h0, e);
      end
      rx_i = 1'b1;
      tick(6);
      n_vec++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL break_busy_release got %b exp 0", busy_o);
      end
      tick(2 * CPB);
      n_vec++;
      if (got_q.size() != 1) begin
         n_err++;
         $display("FAIL break_count got %0d exp 1", got_q.size());
      end
   endtask

   task automatic test_glitch();
      do_reset();
      ready_i = 1'b1;
      rx_i = 1'b0;
      tick(5);
      rx_i = 1'b1;
      n_vec++;
      if (busy_o !== 1'b1) begin
         n_err++;
         $display("FAIL glitch_busy_start got %b exp 1", busy_o);
      end
      tick(8);
      n_vec++;
      if (busy_o !== 1'b0) begin
         n_err++;
         $display("FAIL glitch_busy_end got %b exp 0", busy_o);
      end
      tick(12 * CPB);
      n_vec++;
      if (got_q.size() != 0) begin
         n_err++;
         $display("FAIL glitch_count got %0d exp 0", got_q.size());
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b;
      do_reset();
      for (int i = 1; i <= DEPTH + 2; i++) begin
         b = 8'(i);
         send_byte(b, ^b, 1'b1);
      end
      n_vec++;
      if (overflow_o !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_flag got %b exp 1", overflow_o);
      end
      n_vec++;
      if (drop_cnt_o !== DCW'(2)) begin
         n_err++;
         $display("FAIL ovf_drop_cnt got %0d exp 2", drop_cnt_o);
      end
      ready_i = 1'b1;
      tick(DEPTH + 2);
      ready_i = 1'b0;
      n_vec++;
      if (got_q.size() != DEPTH) begin
         n_err++;
         $display("FAIL ovf_count got %0d exp %0d", got_q.size(), DEPTH);
      end
      for (int i = 0; i < DEPTH; i++) begin
         n_vec++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL ovf_entry%0d got %h exp %h", i,
                     (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
      n_vec++;
      if (valid_o !== 1'b0) begin
         n_err++;
         $display("FAIL ovf_drained_valid got %b exp 0", valid_o);
      end
   endtask

   task automatic test_full_pop();
      logic [7:0] b;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         send_byte(b, ^b, 1'b1);
      end
      b = 8'($urandom);
      fork
         send_byte(b, ^b, 1'b1);
         begin
            tick(ExpLat - 1);
            ready_i = 1'b1;
            tick(2);
            ready_i = 1'b0;
         end
      join
      n_vec++;
      if (drop_cnt_o !== '0 || overflow_o !== 1'b0) begin
         n_err++;
         $display("FAIL fullpop_drop got cnt=%0d ovf=%b exp cnt=0 ovf=0", drop_cnt_o, overflow_o);
      end
      n_vec++;
      if (valid_o !== 1'b1) begin
         n_err++;
         $display("FAIL fullpop_valid got %b exp 1", valid_o);
      end
      ready_i = 1'b1;
      tick(DEPTH + 2);
      ready_i = 1'b0;
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL fullpop_count got %0d exp %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_vec++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL fullpop_entry%0d got %h exp %h", i,
                     (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] v;
      do_reset();
      send_byte(8'h5A, ^8'h5A, 1'b1);
      v = 8'h7E;
      rx_i = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         rx_i = v[i];
         tick(CPB);
      end
      rst_i = 1'b1;
      rx_i  = 1'b1;
      #1;
      n_vec++;
      if ({data_o, frame_err_o, valid_o, busy_o, overflow_o, drop_cnt_o} !== '0) begin
         n_err++;
         $display("FAIL midrst_outputs got data=%h ferr=%b valid=%b busy=%b ovf=%b drops=%0d exp all 0",
                  data_o, frame_err_o, valid_o, busy_o, overflow_o, drop_cnt_o);
      end
      tick(2);
      rst_i = 1'b0;
      tick(2);
      exp_q.delete();
      got_q.delete();
      ready_i = 1'b1;
      send_byte(8'h31, ^8'h31, 1'b1);
      tick(4);
      n_vec++;
      if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
         n_err++;
         $display("FAIL midrst_entry got n=%0d first=%h exp n=1 first=%h", got_q.size(),
                  (got_q.size() > 0) ? got_q[0] : 9'h1ff, exp_q[0]);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic       par;
      logic       stp;
      bit         done;
      do_reset();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               b   = 8'($urandom);
               par = (^b) ^ ($urandom_range(0, 3) == 0);
               stp = ($urandom_range(0, 3) != 0);
               send_byte(b, par, stp);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               ready_i = 1'($urandom_range(0, 1));
               tick(1);
            end
         end
      join
      ready_i = 1'b1;
      tick(DEPTH + 4);
      ready_i = 1'b0;
      n_vec++;
      if (got_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size(); i++) begin
         n_vec++;
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL random_entry%0d got %h exp %h", i,
                     (i < got_q.size()) ? got_q[i] : 9'h1ff, exp_q[i]);
         end
      end
   endtask

`ifdef CHESHIRE_SIM_UART_PARITY_EN
   task automatic test_parity();
      do_reset();
      ready_i = 1'b1;
      send_byte(8'h07, 1'b0, 1'b1);
      send_byte(8'h07, 1'b1, 1'b1);
      tick(4);
      n_vec++;
      if (got_q.size() != 2) begin
         n_err++;
         $display("FAIL parity_count got %0d exp 2", got_q.size());
      end
      n_vec++;
      if (got_q.size() < 1 || got_q[0] !== 9'h107) begin
         n_err++;
         $display("FAIL parity_bad got %h exp 107", (got_q.size() > 0) ? got_q[0] : 9'h0);
      end
      n_vec++;
      if (got_q.size() < 2 || got_q[1] !== 9'h007) begin
         n_err++;
         $display("FAIL parity_good got %h exp 007", (got_q.size() > 1) ? got_q[1] : 9'h1ff);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_break();
      test_glitch();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      test_random();
`ifdef CHESHIRE_SIM_UART_PARITY_EN
      test_parity();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cheshire_sim_uart_rx.md
Name: cheshire_sim_uart_rx

Overview:
Simulation-side UART receiver that consumes the `uart_tx` serial line of the Verilator Cheshire SoC wrapper. It oversamples with the system clock, deframes 8N1 characters, and buffers them in a small FIFO. The C++ harness drains the FIFO through a valid/ready port, so console output is decoded in RTL rather than bit-banged in C++.

Parameters:
- ClkPerBit, 1736: system clock cycles per UART bit (200 MHz / 115200 baud). Must be >= 4.
- FifoDepth, 16: character FIFO entries. Must be a power of two, >= 2.
- DropCntWidth, 16: width of the dropped-character counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- rx_i  in  1  serial line from SoC `uart_tx`; idles high
- data_o  out  8  head-of-FIFO character
- frame_err_o  out  1  head character had a bad stop bit (or parity, see optional feature)
- valid_o  out  1  FIFO not empty
- ready_i  in  1  consumer accepts head entry
- busy_o  out  1  receiver FSM not in IDLE
- overflow_o  out  1  sticky: at least one character dropped
- drop_cnt_o  out  DropCntWidth  saturating count of dropped characters

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset values:
  - sync flops = 1
  - data_o = 0, frame_err_o = 0, valid_o = 0, busy_o = 0, overflow_o = 0, drop_cnt_o = 0
  - FSM = IDLE, FIFO empty
- Input synchronizer: 2-flop on rx_i. All decisions use the synchronized signal `rxs`.
- Bit-timer: down-counter, width $clog2(ClkPerBit). A sample event fires when the counter reaches 0, then the counter reloads ClkPerBit-1.
- FSM states and transitions:
  - IDLE: on rxs==0, go to START; load counter with ClkPerBit/2-1.
  - START: on sample event, if rxs==0 go to DATA with bit index 0; else glitch, return to IDLE with no push.
  - DATA: on each sample event, shift rxs into the shift register LSB-first. After bit index 7, go to STOP.
  - STOP: on sample event, push {frame_err = ~rxs, byte}. If rxs==1, go to IDLE. If rxs==0 (break or framing error), go to BREAK.
  - BREAK: wait for rxs==1, then IDLE. No further pushes in this state.
- Latency: the entry appears on valid_o 1 cycle after the stop sample. The stop sample occurs at 2 + ClkPerBit/2 + 9*ClkPerBit cycles after the rx_i falling edge, ±1 cycle.
- FIFO: first-word-fall-through.
  - Pop occurs when valid_o && ready_i.
  - Push while full with no same-cycle pop: drop the character, set overflow_o, increment drop_cnt_o (saturate at all-ones).
  - Push while full with a same-cycle pop: accepted, no drop.
  - Push and pop on an empty FIFO: the push is stored and valid_o rises next cycle.
- Pointers: log2(FifoDepth)+1 bits, wrap naturally. Full when MSBs differ and LSBs are equal.
- ready_i with valid_o==0 has no effect.
- busy_o = (state != IDLE).
- Reset mid-frame: the partial character is discarded, the FIFO is cleared, and the counters are cleared.

Optional Feature:
Macro CHESHIRE_SIM_UART_PARITY_EN.
- Defined:
  - Frames are 8E1. A PARITY state is inserted between DATA and STOP.
  - The sampled parity bit is checked against the XOR of the data bits (even parity).
  - frame_err_o = stop error OR parity error.
  - Latency grows by ClkPerBit.
- Undefined: 8N1 only, no PARITY state.

Decomposition:
- Package cheshire_sim_uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - packed entry struct {logic frame_err; logic [7:0] data}
  - constant DataBits = 8
- Sub-module cheshire_sim_uart_fifo: parameterized by the entry type and FifoDepth.
  - Ports: clk_i and active-high async rst_i; push/full; pop/empty/head.
  - Owned here because common_cells FIFOs use active-low reset.

Test Plan:
- ClkPerBit=16, FifoDepth=4: send 0x55 with a valid stop bit, ready_i=1 → one pop with data_o=0x55, frame_err_o=0, about 154 cycles after the edge.
- Send 0xA3 with the stop bit held low for 3 bit times → entry {1, 0xA3}; busy_o stays high until rx_i returns high; no second entry.
- Send a 5-cycle low glitch on idle rx_i → no entry; busy_o returns to 0 at the start-sample point.
- Send 6 characters 0x01..0x06 with ready_i=0 → FIFO holds 0x01..0x04, overflow_o=1, drop_cnt_o=2; draining yields 0x01..0x04 in order.
- With the FIFO full, assert ready_i in the cycle of the 5th stop-sample push → no drop, drop_cnt_o unchanged, valid_o stays high.
- Assert rst_i mid-DATA of 0x7E, release, then send 0x31 → only 0x31 is received; all outputs read 0 during reset.
- With CHESHIRE_SIM_UART_PARITY_EN defined, send 0x07 with parity bit 0 → frame_err_o=1.
